time_set_ctrl: RTL and testbench

Button-driven controller that sequences manual setting of the digital clock's hour and minute registers. It captures the running BCD time, lets the user step the hour and then the minute field with wrap-around, and blinks the field being edited. It then issues a one-cycle load to the timekeeping counters. It sits between the debounced button logic and the hour/minute counter datapath, alongside the AM/PM indicator logic that consumes the same BCD hour.

---
 rtl/clock_pkg.sv | 27 ++
 rtl/bcd_inc.sv | 26 ++
 rtl/time_set_ctrl.sv | 141 ++++++++++++++
 tb/tb_time_set_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
//==============================================================================
// Module      : clock_pkg
// Description : Shared types and BCD helpers for the clock time-setting path.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        COMMIT   = 2'd3
    } state_t;

    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;

    // With both digits legal, a plain binary compare orders BCD values correctly.
    function automatic logic bcd_legal(input logic [7:0] value, input logic [7:0] max);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) && (value <= max);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_inc.sv
//==============================================================================
// Module      : bcd_inc
// Description : Combinational two-digit BCD increment, wrapping to 00 at limit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bcd_inc (
    input  logic [7:0] value,
    input  logic [7:0] limit,
    output logic [7:0] result
);

    always_comb begin
        if (value >= limit) begin
            result = 8'h00;
        end else if (value[3:0] >= 4'd9) begin
            result = {value[7:4] + 4'd1, 4'd0};
        end else begin
            result = {value[7:4], value[3:0] + 4'd1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/time_set_ctrl.sv
//==============================================================================
// Module      : time_set_ctrl
// Description : Button-driven hour/minute set sequencer with blink and load.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    output logic [7:0] set_hour,
    output logic [7:0] set_min,
    output logic       load,
    output logic       setting,
    output logic       blink_hour,
    output logic       blink_min
);

    localparam logic [5:0] c_idle_last = 6'(TIMEOUT_S - 1);

    state_t     r_state;
    logic [7:0] r_set_hour;
    logic [7:0] r_set_min;
    logic       r_load;
    logic       r_setting;
    logic       r_blink_hour;
    logic       r_blink_min;
    logic       r_blink_phase;
    logic [5:0] r_idle_cnt;

    state_t     w_state_nxt;
    logic [7:0] w_hour_nxt;
    logic [7:0] w_min_nxt;
    logic       w_phase_nxt;
    logic [5:0] w_idle_nxt;
    logic [7:0] w_hour_inc;
    logic [7:0] w_min_inc;

    bcd_inc u_hour_inc (
        .value  (r_set_hour),
        .limit  (HOUR_MAX),
        .result (w_hour_inc)
    );

    bcd_inc u_min_inc (
        .value  (r_set_min),
        .limit  (MIN_MAX),
        .result (w_min_inc)
    );

    // btn_mode outranks btn_inc, and any button outranks the terminal tick.
    always_comb begin
        w_state_nxt = r_state;
        w_hour_nxt  = r_set_hour;
        w_min_nxt   = r_set_min;
        w_phase_nxt = r_blink_phase;
        w_idle_nxt  = r_idle_cnt;
        case (r_state)
            RUN: begin
                w_phase_nxt = 1'b0;
                w_idle_nxt  = 6'd0;
                if (btn_mode) begin
                    w_state_nxt = SET_HOUR;
                    w_hour_nxt  = bcd_legal(cur_hour, HOUR_MAX) ? cur_hour : 8'h00;
                    w_min_nxt   = bcd_legal(cur_min, MIN_MAX) ? cur_min : 8'h00;
                end
            end
            SET_HOUR, SET_MIN: begin
                if (tick_1hz) begin
                    w_phase_nxt = ~r_blink_phase;
                    w_idle_nxt  = r_idle_cnt + 6'd1;
                end
                if (btn_mode) begin
                    w_state_nxt = (r_state == SET_HOUR) ? SET_MIN : COMMIT;
                    w_idle_nxt  = 6'd0;
                end else if (btn_inc) begin
                    if (r_state == SET_HOUR) begin
                        w_hour_nxt = w_hour_inc;
                    end else begin
                        w_min_nxt = w_min_inc;
                    end
                    w_phase_nxt = 1'b0;
                    w_idle_nxt  = 6'd0;
                end else if (tick_1hz && (r_idle_cnt == c_idle_last)) begin
                    w_state_nxt = RUN;
                    w_phase_nxt = 1'b0;
                    w_idle_nxt  = 6'd0;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_phase_nxt = 1'b0;
                w_idle_nxt  = 6'd0;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with r_state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_set_hour    <= 8'h00;
            r_set_min     <= 8'h00;
            r_load        <= 1'b0;
            r_setting     <= 1'b0;
            r_blink_hour  <= 1'b0;
            r_blink_min   <= 1'b0;
            r_blink_phase <= 1'b0;
            r_idle_cnt    <= 6'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_set_hour    <= w_hour_nxt;
            r_set_min     <= w_min_nxt;
            r_load        <= (w_state_nxt == COMMIT);
            r_setting     <= (w_state_nxt != RUN);
            r_blink_hour  <= (w_state_nxt == SET_HOUR) && w_phase_nxt;
            r_blink_min   <= (w_state_nxt == SET_MIN) && w_phase_nxt;
            r_blink_phase <= w_phase_nxt;
            r_idle_cnt    <= w_idle_nxt;
        end
    end

    assign set_hour   = r_set_hour;
    assign set_min    = r_set_min;
    assign load       = r_load;
    assign setting    = r_setting;
    assign blink_hour = r_blink_hour;
    assign blink_min  = r_blink_min;

endmodule

`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
//==============================================================================
// Module      : tb_time_set_ctrl
// Description : Directed self-checking bench for time_set_ctrl (TIMEOUT_S=3).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_time_set_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic [7:0] cur_hour;
    logic [7:0] cur_min;
    logic [7:0] set_hour;
    logic [7:0] set_min;
    logic       load;
    logic       setting;
    logic       blink_hour;
    logic       blink_min;

    int n_checks = 0;
    int n_pass   = 0;
    int load_cnt = 0;
    int exp_load = 0;

    time_set_ctrl #(.TIMEOUT_S(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1hz   (tick_1hz),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .set_hour   (set_hour),
        .set_min    (set_min),
        .load       (load),
        .setting    (setting),
        .blink_hour (blink_hour),
        .blink_min  (blink_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load === 1'b1) load_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock cycle with the given pulses; returns #1 after the edge.
    task automatic step(input logic m, input logic i, input logic t);
        @(negedge clk);
        btn_mode = m;
        btn_inc  = i;
        tick_1hz = t;
        @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        tick_1hz = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        cur_hour = 8'h00; cur_min = 8'h00;
        do_reset();
        #1;
        check("rst_setting", setting, 0);
        check("rst_hour", set_hour, 8'h00);
        check("rst_min", set_min, 8'h00);
        check("rst_load", load, 0);
        check("rst_blink", {blink_hour, blink_min}, 0);

        // capture and blink
        cur_hour = 8'h14; cur_min = 8'h37;
        step(1, 0, 0);
        check("cap_setting", setting, 1);
        check("cap_hour", set_hour, 8'h14);
        check("cap_min", set_min, 8'h37);
        check("cap_blink", blink_hour, 0);
        step(0, 0, 1);
        check("tick_blink_hour", {blink_hour, blink_min}, 2'b10);
        step(0, 1, 0);
        check("inc_clears_blink", blink_hour, 0);
        check("inc_hour_15", set_hour, 8'h15);
        do_reset();

        // hour wrap 22->23->00, minute wrap 59->00
        cur_hour = 8'h22; cur_min = 8'h59;
        step(1, 0, 0);
        step(0, 1, 0);
        check("hour_23", set_hour, 8'h23);
        step(0, 1, 0);
        check("hour_wrap", set_hour, 8'h00);
        step(1, 0, 0);
        step(0, 1, 0);
        check("min_wrap", set_min, 8'h00);
        check("min_wrap_hour", set_hour, 8'h00);
        do_reset();

        // digit carries 19->20, 09->10
        cur_hour = 8'h19; cur_min = 8'h09;
        step(1, 0, 0);
        step(0, 1, 0);
        check("hour_carry", set_hour, 8'h20);
        step(1, 0, 0);
        step(0, 1, 0);
        check("min_carry", set_min, 8'h10);
        do_reset();

        // full sequence with commit
        exp_load = load_cnt;
        cur_hour = 8'h05; cur_min = 8'h30;
        step(1, 0, 0);
        step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
        check("seq_hour", set_hour, 8'h08);
        step(1, 0, 0);
        step(0, 1, 0);
        check("seq_min", set_min, 8'h31);
        step(1, 0, 0);
        check("commit_load", load, 1);
        check("commit_setting", setting, 1);
        check("commit_val", {set_hour, set_min}, 16'h0831);
        step(0, 0, 0);
        check("post_load", load, 0);
        check("post_setting", setting, 0);
        check("post_val", {set_hour, set_min}, 16'h0831);
        check("load_once", load_cnt, exp_load + 1);

        // simultaneous mode+inc, then timeout
        cur_hour = 8'h10; cur_min = 8'h00;
        step(1, 0, 0);
        step(1, 1, 0);
        check("both_hour", set_hour, 8'h10);
        step(0, 0, 1);
        check("both_in_setmin", {blink_hour, blink_min}, 2'b01);
        step(0, 1, 0);
        check("both_min_inc", set_min, 8'h01);
        exp_load = load_cnt;
        step(0, 0, 1); step(0, 0, 1);
        check("to_before", setting, 1);
        step(0, 0, 1);
        check("to_fired", setting, 0);
        step(0, 0, 0);
        check("to_no_load", load_cnt, exp_load);
        check("to_shadow_kept", set_min, 8'h01);

        // inc on terminal tick keeps the edit alive
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 1); step(0, 0, 1);
        step(0, 1, 1);
        check("inc_on_tick_setting", setting, 1);
        check("inc_on_tick_min", set_min, 8'h01);
        step(0, 0, 1); step(0, 0, 1);
        check("restart_before", setting, 1);
        step(0, 0, 1);
        check("restart_fired", setting, 0);

        // inc ignored in RUN
        step(0, 1, 0);
        check("run_inc_setting", setting, 0);
        check("run_inc_min", set_min, 8'h01);

        // illegal captures
        cur_hour = 8'h2A; cur_min = 8'h37;
        step(1, 0, 0);
        check("illegal_hour", set_hour, 8'h00);
        check("legal_min", set_min, 8'h37);
        step(0, 0, 0);
        do_reset();
        cur_hour = 8'h24; cur_min = 8'h60;
        step(1, 0, 0);
        check("range_capture", {set_hour, set_min}, 16'h0000);

        // reset mid-edit
        cur_hour = 8'h11; cur_min = 8'h22;
        do_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        exp_load = load_cnt;
        do_reset();
        #1;
        check("midrst_outs", {set_hour, set_min, load, setting, blink_hour, blink_min}, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        check("midrst_no_load", load_cnt, exp_load);
        check("midrst_setting", setting, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
